// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver.
//
// Deserializes the asynchronous PS2_CLK/PS2_DAT pair into 8-bit scan-code bytes.
// Each frame is 11 bits: start (0), eight data bits LSB first, odd parity, stop (1).
// Make, break (0xF0) and extended (0xE0) codes are passed through undecoded.
//
// Parameters:
//   FILTER_LEN     - consecutive equal synchronized samples before the filtered clock moves
//   TIMEOUT_CYCLES - Clock cycles without a falling edge, mid-frame, before abandoning a frame
//
// Ports:
//   Clock     - system clock, rising edge
//   nReset    - asynchronous active-low reset
//   PS2_CLK   - keyboard clock (asynchronous, idle high)
//   PS2_DAT   - keyboard data (asynchronous, idle high)
//   data      - last good byte, held until the next good byte
//   data_en   - one-cycle strobe, data valid in the same cycle
//   frame_err - one-cycle strobe on a rejected or timed-out frame
//
// Build option:
//   PS2_PARITY_CHECK_EN - when defined, frames with bad odd parity are rejected;
//                         otherwise the parity bit is consumed and ignored.

module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } t_state;

    // Synchronizers, reset to the idle-high line level.
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          w_clk_s;
    logic          w_dat_s;

    // Clock filter and edge detect.
    logic          r_fclk;
    logic          w_fclk_next;
    logic [FW-1:0] r_filt_cnt;
    logic [FW-1:0] w_filt_next;
    logic          r_fall;
    logic          w_fall_next;

    // Frame FSM and datapath.
    t_state        r_state;
    t_state        w_state_next;
    logic [2:0]    r_bit_cnt;
    logic [2:0]    w_bit_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_next;
    logic          w_timeout;
    logic          w_par_ok;

    logic [7:0]    r_data;
    logic [7:0]    w_data_next;
    logic          r_data_en;
    logic          w_data_en_next;
    logic          r_frame_err;
    logic          w_frame_err_next;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    // Filtered clock follows the synchronized clock only once it has disagreed
    // for FILTER_LEN consecutive samples; any agreeing sample restarts the count.
    always_comb begin
        w_fclk_next = r_fclk;
        w_filt_next = r_filt_cnt;
        if (w_clk_s == r_fclk) begin
            w_filt_next = '0;
        end else if (r_filt_cnt >= FW'(FILTER_LEN - 1)) begin
            w_fclk_next = w_clk_s;
            w_filt_next = '0;
        end else begin
            w_filt_next = r_filt_cnt + 1'b1;
        end
        w_fall_next = r_fclk & ~w_fclk_next;
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    logic w_parity_next;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign w_par_ok = ^{r_shift, r_parity};

    always_comb begin
        w_parity_next = r_parity;
        if (r_state == StParity && r_fall) begin
            w_parity_next = w_dat_s;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`else
    assign w_par_ok = 1'b1;
`endif

    // A fall in the same cycle as the timeout wins: the frame keeps going.
    assign w_timeout = (r_state != StIdle) && !r_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_next     = r_state;
        w_bit_next       = r_bit_cnt;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_data_en_next   = 1'b0;
        w_frame_err_next = 1'b0;

        if (r_fall || r_state == StIdle) begin
            w_to_next = '0;
        end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
            w_to_next = r_to_cnt + 1'b1;
        end else begin
            w_to_next = r_to_cnt;
        end

        unique case (r_state)
            StIdle: begin
                // A fall with data high is a spurious edge, not a start bit.
                if (r_fall && !w_dat_s) begin
                    w_state_next = StData;
                    w_bit_next   = 3'd0;
                end
            end
            StData: begin
                if (r_fall) begin
                    w_shift_next = {w_dat_s, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = StParity;
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            StParity: begin
                if (r_fall) begin
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (r_fall) begin
                    w_state_next = StIdle;
                    if (w_dat_s && w_par_ok) begin
                        w_data_next    = r_shift;
                        w_data_en_next = 1'b1;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase

        if (w_timeout) begin
            w_state_next     = StIdle;
            w_frame_err_next = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_clk_sync  <= 2'b11;
            r_dat_sync  <= 2'b11;
            r_fclk      <= 1'b1;
            r_filt_cnt  <= '0;
            r_fall      <= 1'b0;
            r_state     <= StIdle;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_to_cnt    <= '0;
            r_data      <= 8'h00;
            r_data_en   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync  <= {r_dat_sync[0], PS2_DAT};
            r_fclk      <= w_fclk_next;
            r_filt_cnt  <= w_filt_next;
            r_fall      <= w_fall_next;
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_to_cnt    <= w_to_next;
            r_data      <= w_data_next;
            r_data_en   <= w_data_en_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    assign data      = r_data;
    assign data_en   = r_data_en;
    assign frame_err = r_frame_err;

endmodule
